// File: rtl/wb_dsp_pkg.sv
// wb_dsp_pkg: shared state encoding and constants for the DSP Wishbone copy sequencer
//  state_t    3-bit FSM encoding
//  STRIDE_DEF default byte increment per copied word
//  SEL_FULL   all four byte lanes enabled
package wb_dsp_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE, S_ERROR
   } state_t;
   localparam int STRIDE_DEF = 4;
   localparam logic [3:0] SEL_FULL = 4'hF;
endpackage

// File: rtl/wb_dsp_addr_gen.sv
// wb_dsp_addr_gen: loadable address register that steps by STRIDE, wrapping modulo 2^aw
//  wb_clk, wb_rst  clock, async active-high reset
//  load/load_addr  load a new start address (wins over inc)
//  inc             advance by STRIDE bytes
//  addr            current address
//  addr_next       value addr takes at the next edge, for registered consumers
module wb_dsp_addr_gen
   import wb_dsp_pkg::*;
#(
   parameter int aw     = 32,
   parameter int STRIDE = STRIDE_DEF
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic          load,
   input  logic          inc,
   input  logic [aw-1:0] load_addr,
   output logic [aw-1:0] addr,
   output logic [aw-1:0] addr_next
);
   always_comb addr_next = load ? load_addr : inc ? addr + aw'(STRIDE) : addr;
   always_ff @(posedge wb_clk or posedge wb_rst)
      if (wb_rst) addr <= '0;
      else addr <= addr_next;
endmodule

// File: rtl/wb_dsp_copy_sequencer.sv
// wb_dsp_copy_sequencer: block copy via single-word Wishbone master read/write pairs
//  cmd_valid/cmd_ready, cmd_src, cmd_dst, cmd_count  copy command (accepted in IDLE)
//  busy, done, error, words_done                     status to DSP control
//  master_start/address/selection/write/data_wr      request to the bus master
//  master_data_rd, master_ack, master_err            response from the bus master
module wb_dsp_copy_sequencer
   import wb_dsp_pkg::*;
#(
   parameter int aw     = 32,
   parameter int dw     = 32,
   parameter int CW     = 16,
   parameter int STRIDE = STRIDE_DEF
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [aw-1:0] cmd_src,
   input  logic [aw-1:0] cmd_dst,
   input  logic [CW-1:0] cmd_count,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [CW-1:0] words_done,
   output logic          master_start,
   output logic [aw-1:0] master_address,
   output logic [3:0]    master_selection,
   output logic          master_write,
   output logic [dw-1:0] master_data_wr,
   input  logic [dw-1:0] master_data_rd,
   input  logic          master_ack,
   input  logic          master_err
);
   state_t state, state_nxt;
   logic [CW-1:0] remaining;
   logic [dw-1:0] hold;
   logic [aw-1:0] src, src_nxt, dst, dst_nxt, address_d;
   logic accept, rd_ack, wr_ack, start_d, write_d;
   // err wins over a simultaneous ack
   assign accept = state == S_IDLE && cmd_valid;
   assign rd_ack = state == S_RD_WAIT && master_ack && !master_err;
   assign wr_ack = state == S_WR_WAIT && master_ack && !master_err;
   assign master_data_wr = hold;
   wb_dsp_addr_gen #(.aw(aw), .STRIDE(STRIDE)) u_src (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .load(accept), .inc(wr_ack),
      .load_addr(cmd_src), .addr(src), .addr_next(src_nxt)
   );
   wb_dsp_addr_gen #(.aw(aw), .STRIDE(STRIDE)) u_dst (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .load(accept), .inc(wr_ack),
      .load_addr(cmd_dst), .addr(dst), .addr_next(dst_nxt)
   );
   always_ff @(posedge wb_clk or posedge wb_rst)
      if (wb_rst) state <= S_IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (cmd_valid) state_nxt = cmd_count == '0 ? S_DONE : S_RD_REQ;
         S_RD_REQ:  state_nxt = S_RD_WAIT;
         S_RD_WAIT: state_nxt = master_err ? S_ERROR : master_ack ? S_WR_REQ : S_RD_WAIT;
         S_WR_REQ:  state_nxt = S_WR_WAIT;
         S_WR_WAIT: state_nxt = master_err ? S_ERROR :
                                master_ack ? (remaining == CW'(1) ? S_DONE : S_RD_REQ) : S_WR_WAIT;
         default:   state_nxt = S_IDLE;
      endcase
   end
   // Outputs are registered from the next state, so request fields use the
   // post-increment addresses and stay frozen between requests.
   always_comb begin
      start_d   = state_nxt == S_RD_REQ || state_nxt == S_WR_REQ;
      address_d = state_nxt == S_RD_REQ ? src_nxt : state_nxt == S_WR_REQ ? dst_nxt : master_address;
      write_d   = start_d ? state_nxt == S_WR_REQ : master_write;
   end
   always_ff @(posedge wb_clk or posedge wb_rst)
      if (wb_rst) begin
         cmd_ready        <= 1'b1;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         words_done       <= '0;
         master_start     <= 1'b0;
         master_address   <= '0;
         master_selection <= '0;
         master_write     <= 1'b0;
         remaining        <= '0;
         hold             <= '0;
      end else begin
         cmd_ready        <= state_nxt == S_IDLE;
         busy             <= state_nxt != S_IDLE;
         done             <= state_nxt == S_DONE;
         error            <= state_nxt == S_ERROR;
         master_start     <= start_d;
         master_address   <= address_d;
         master_selection <= SEL_FULL;
         master_write     <= write_d;
         if (accept) begin
            remaining  <= cmd_count;
            words_done <= '0;
         end
         if (rd_ack) hold <= master_data_rd;
         if (wr_ack) begin
            remaining <= remaining - CW'(1);
            if (words_done != '1) words_done <= words_done + CW'(1);
         end
      end
endmodule
